// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared states, response codes and command record for the APB master
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_SLVERR  = 2'b01,
        RSP_TIMEOUT = 2'b10
    } rsp_err_e;

    localparam int CMD_ADDR_W = 6;
    localparam int CMD_DATA_W = 32;

    // Command record at the default bus geometry; the top rebuilds it at its own widths
    typedef struct packed {
        logic                    write;
        logic [CMD_ADDR_W-1:0]   addr;
        logic [CMD_DATA_W-1:0]   wdata;
        logic [CMD_DATA_W/8-1:0] strb;
    } cmd_t;

endpackage

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - command/response handshake plus APB bus bundle
interface apb_master_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [DATA_W/8-1:0] cmd_strb;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_rdata;
    logic [1:0]          rsp_err;

    logic [ADDR_W-1:0]   paddr;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic                pwrite;
    logic                psel;
    logic                penable;
    logic [DATA_W-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output paddr, pwdata, pstrb, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  paddr, pwdata, pstrb, pwrite, psel, penable,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_cmd_fifo.sv
// rtl/apb_cmd_fifo.sv - in-order command queue, pointers carry an extra wrap bit
module apb_cmd_fifo
    import apb_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = cmd_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  T     din_i,
    output logic full_o,
    input  logic pop_i,
    output T     dout_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          do_push;
    logic          do_pop;

    // Same index with differing wrap bits means the writer has lapped the reader
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + (AW+1)'(1);
        if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB master: queued commands run as SETUP/ACCESS transfers with
// a bounded wait and a single held response slot
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    apb_master_if.master bus_if
);
    localparam int SW = DATA_W / 8;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SW-1:0]     strb;
    } cmd_w_t;

    cmd_w_t fifo_din;
    cmd_w_t fifo_dout;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_pop;

    apb_state_e        state_q,     state_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic [SW-1:0]     pstrb_q,     pstrb_d;
    logic              pwrite_q,    pwrite_d;
    logic [TW-1:0]     tmo_q,       tmo_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    rsp_err_e          rsp_err_q,   rsp_err_d;
    logic              rsp_free;

    assign fifo_din = '{write: bus_if.cmd_write,
                        addr:  bus_if.cmd_addr,
                        wdata: bus_if.cmd_wdata,
                        strb:  bus_if.cmd_strb};

    apb_cmd_fifo #(
        .DEPTH (DEPTH),
        .T     (cmd_w_t)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus_if.cmd_valid),
        .din_i   (fifo_din),
        .full_o  (fifo_full),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty)
    );

    // The slot is free next cycle if empty now or being consumed now, so SETUP
    // never overlaps a held response yet back-to-back transfers keep a 3-cycle pitch
    assign rsp_free = !rsp_valid_q || bus_if.rsp_ready;

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pwrite_d    = pwrite_q;
        tmo_d       = tmo_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;

        if (rsp_valid_q && bus_if.rsp_ready) rsp_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && rsp_free) begin
                    fifo_pop = 1'b1;
                    paddr_d  = fifo_dout.addr;
                    pwdata_d = fifo_dout.wdata;
                    pwrite_d = fifo_dout.write;
                    pstrb_d  = fifo_dout.write ? fifo_dout.strb : '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                tmo_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // pready is tested first so a completion on the limit cycle is not aborted
                if (bus_if.pready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : bus_if.prdata;
                    rsp_err_d   = bus_if.pslverr ? RSP_SLVERR : RSP_OK;
                end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = RSP_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pwrite_q    <= 1'b0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= RSP_OK;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pwrite_q    <= pwrite_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus_if.cmd_ready = !fifo_full;
    assign bus_if.psel      = (state_q != IDLE);
    assign bus_if.penable   = (state_q == ACCESS);
    assign bus_if.paddr     = paddr_q;
    assign bus_if.pwdata    = pwdata_q;
    assign bus_if.pstrb     = pstrb_q;
    assign bus_if.pwrite    = pwrite_q;
    assign bus_if.rsp_valid = rsp_valid_q;
    assign bus_if.rsp_rdata = rsp_rdata_q;
    assign bus_if.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed bench with a transfer-level reference model for apb_master
module tb_apb_master;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam logic [5:0] HANG_ADDR = 6'h3F;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_master_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    apb_master #(
        .ADDR_W  (6),
        .DATA_W  (32),
        .DEPTH   (DEPTH),
        .TIMEOUT (TMO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus.master)
    );

    int          errors = 0;
    int          checks = 0;
    int          cfg_wait = 0;
    logic [31:0] cfg_rdata = '0;
    logic        cfg_slverr = 1'b0;
    int          acc_cnt;

    // Completer: ready after cfg_wait wait states, never ready at HANG_ADDR
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_cnt <= 0;
        else if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end
    assign bus.pready  = bus.psel && bus.penable && (bus.paddr != HANG_ADDR) && (acc_cnt >= cfg_wait);
    assign bus.prdata  = cfg_rdata;
    assign bus.pslverr = cfg_slverr && bus.pready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        w;
        logic [5:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
    } mcmd_t;

    mcmd_t       exp_q[$];
    mcmd_t       cur;
    mcmd_t       m;
    bit          in_xfer = 0;
    bit          pend_done = 0;
    logic [1:0]  pend_err;
    logic [31:0] pend_data;
    bit          exp_rv = 0;
    logic [1:0]  exp_err;
    logic [31:0] exp_data;
    bit          prev_consume = 0;
    int          acc_n = 0;
    int          last_acc = 0;
    int          cyc = 0;
    logic [5:0]  setup_addr[$];
    int          setup_cyc[$];

    // Reference model and per-cycle comparison
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_psel", bus.psel, 0);
                chk("rst_penable", bus.penable, 0);
                chk("rst_rsp_valid", bus.rsp_valid, 0);
                chk("rst_cmd_ready", bus.cmd_ready, 1);
                chk("rst_paddr", bus.paddr, 0);
                chk("rst_pstrb", bus.pstrb, 0);
                chk("rst_rsp_err", bus.rsp_err, 0);
                exp_q.delete();
                in_xfer = 0; pend_done = 0; exp_rv = 0; prev_consume = 0; acc_n = 0;
            end else begin
                if (pend_done) begin
                    exp_rv = 1; exp_err = pend_err; exp_data = pend_data; pend_done = 0;
                end else if (prev_consume) begin
                    exp_rv = 0;
                end
                chk("rsp_valid", bus.rsp_valid, exp_rv);
                if (exp_rv) begin
                    chk("rsp_err", bus.rsp_err, exp_err);
                    chk("rsp_rdata", bus.rsp_rdata, exp_data);
                end
                prev_consume = exp_rv && bus.rsp_ready;

                if (bus.psel && !bus.penable) begin
                    chk("setup_while_busy", in_xfer, 0);
                    chk("setup_while_rsp", exp_rv, 0);
                    chk("setup_fifo_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        chk("setup_paddr", bus.paddr, cur.a);
                        chk("setup_pwrite", bus.pwrite, cur.w);
                        chk("setup_pwdata", bus.pwdata, cur.d);
                        chk("setup_pstrb", bus.pstrb, cur.w ? cur.s : 4'h0);
                        setup_addr.push_back(bus.paddr);
                        setup_cyc.push_back(cyc);
                    end
                    in_xfer = 1; acc_n = 0;
                end else if (bus.psel && bus.penable) begin
                    chk("access_without_setup", in_xfer, 1);
                    acc_n++;
                    chk("stable_paddr", bus.paddr, cur.a);
                    chk("stable_pwrite", bus.pwrite, cur.w);
                    chk("stable_pwdata", bus.pwdata, cur.d);
                    chk("stable_pstrb", bus.pstrb, cur.w ? cur.s : 4'h0);
                    if (bus.pready) begin
                        pend_done = 1;
                        pend_err  = bus.pslverr ? 2'b01 : 2'b00;
                        pend_data = cur.w ? 32'h0 : bus.prdata;
                        in_xfer = 0; last_acc = acc_n;
                    end else if (acc_n == TMO) begin
                        pend_done = 1; pend_err = 2'b10; pend_data = 32'h0;
                        in_xfer = 0; last_acc = acc_n;
                    end
                end else begin
                    chk("penable_without_psel", bus.penable, 0);
                    chk("xfer_dropped", in_xfer, 0);
                    in_xfer = 0;
                end

                chk("cmd_ready", bus.cmd_ready, exp_q.size() < DEPTH);
                if (bus.cmd_valid && bus.cmd_ready) begin
                    m.w = bus.cmd_write; m.a = bus.cmd_addr; m.d = bus.cmd_wdata; m.s = bus.cmd_strb;
                    exp_q.push_back(m);
                end
            end
        end
    end

    task automatic push_cmd(input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_strb = s;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); ok = bus.cmd_ready;
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        chk("push_accepted", ok, 1);
    endtask

    task automatic wait_rsp(output logic [1:0] err, output logic [31:0] data);
        bit seen = 0;
        err = '0; data = '0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin seen = 1; err = bus.rsp_err; data = bus.rsp_rdata; end
        end
        chk("rsp_arrives", seen, 1);
    endtask

    task automatic wait_quiet();
        bit q = 0;
        for (int i = 0; i < 400 && !q; i++) begin
            @(negedge clk);
            q = (exp_q.size() == 0) && !in_xfer && !pend_done && !bus.rsp_valid;
        end
        chk("bus_quiet", q, 1);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    logic [1:0]  r_err;
    logic [31:0] r_data;

    initial begin
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.cmd_strb = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("init_paddr", bus.paddr, 0);
        chk("init_pwdata", bus.pwdata, 0);
        chk("init_pwrite", bus.pwrite, 0);
        chk("init_rsp_rdata", bus.rsp_rdata, 0);
        chk("init_cmd_ready", bus.cmd_ready, 1);
        chk("init_psel", bus.psel, 0);

        // Zero-wait write
        cfg_wait = 0;
        push_cmd(1'b1, 6'h0C, 32'hDEADBEEF, 4'hF);
        wait_rsp(r_err, r_data);
        chk("wr_err", r_err, 2'b00);
        chk("wr_rdata", r_data, 32'h0);
        chk("wr_psel_cycles", last_acc + 1, 2);

        // Read with three wait states
        cfg_wait = 3; cfg_rdata = 32'h12345678;
        push_cmd(1'b0, 6'h10, 32'h55AA55AA, 4'hF);
        wait_rsp(r_err, r_data);
        chk("rd_err", r_err, 2'b00);
        chk("rd_rdata", r_data, 32'h12345678);
        chk("rd_penable_cycles", last_acc, 4);

        // Completer error
        cfg_wait = 1; cfg_slverr = 1'b1; cfg_rdata = 32'hA5A50001;
        push_cmd(1'b0, 6'h08, 32'h0, 4'h0);
        wait_rsp(r_err, r_data);
        chk("slverr_err", r_err, 2'b01);
        chk("slverr_rdata", r_data, 32'hA5A50001);
        cfg_slverr = 1'b0;

        // Ready on the last allowed cycle still completes normally
        cfg_wait = 15; cfg_rdata = 32'h0BADF00D;
        push_cmd(1'b0, 6'h12, 32'h0, 4'h0);
        wait_rsp(r_err, r_data);
        chk("edge_err", r_err, 2'b00);
        chk("edge_rdata", r_data, 32'h0BADF00D);
        chk("edge_penable_cycles", last_acc, 16);

        // Timeout then a queued write behind it
        cfg_wait = 0;
        push_cmd(1'b0, HANG_ADDR, 32'h0, 4'h0);
        push_cmd(1'b1, 6'h04, 32'h000000FF, 4'h3);
        wait_rsp(r_err, r_data);
        chk("tmo_err", r_err, 2'b10);
        chk("tmo_rdata", r_data, 32'h0);
        chk("tmo_penable_cycles", last_acc, 16);
        wait_rsp(r_err, r_data);
        chk("after_tmo_err", r_err, 2'b00);

        // Fill the FIFO behind a held response, then drain in order
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        push_cmd(1'b1, 6'h30, 32'h30303030, 4'h1);
        wait_rsp(r_err, r_data);
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 6'h20 + 6'(i), 32'hC0DE0000 + i, 4'hF);
        @(negedge clk);
        chk("full_cmd_ready", bus.cmd_ready, 0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 6'h24; bus.cmd_wdata = 32'hFFFF0000; bus.cmd_strb = 4'hF;
        repeat (4) begin
            @(negedge clk);
            chk("full_ignored", bus.cmd_ready, 0);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        setup_addr.delete(); setup_cyc.delete();
        bus.rsp_ready = 1'b1;
        wait_quiet();
        chk("drain_count", setup_addr.size(), 4);
        if (setup_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("drain_order", setup_addr[i], 6'h20 + 6'(i));
            for (int i = 0; i < 3; i++) chk("drain_spacing", setup_cyc[i+1] - setup_cyc[i], 3);
        end

        // Reset in the middle of ACCESS
        push_cmd(1'b0, HANG_ADDR, 32'h0, 4'h0);
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = bus.penable; end
            chk("reach_access", seen, 1);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_psel", bus.psel, 0);
        chk("rst_mid_penable", bus.penable, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);
        chk("post_rst_rsp_valid", bus.rsp_valid, 0);
        repeat (20) @(negedge clk);
        cfg_wait = 0; cfg_rdata = 32'hCAFE0011;
        push_cmd(1'b0, 6'h11, 32'h0, 4'h0);
        wait_rsp(r_err, r_data);
        chk("post_rst_rdata", r_data, 32'hCAFE0011);
        chk("post_rst_err", r_err, 2'b00);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 6, width of APB address and cmd_addr.
REQ-002 Parameter DATA_W, default 32, APB data width; legal values are 8, 16 and 32.
REQ-003 Parameter DEPTH, default 4, command FIFO entries; power of 2, at least 2.
REQ-004 Parameter TIMEOUT, default 16, maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 cmd_valid  in  1  command offered.
REQ-009 cmd_ready  out  1  FIFO can accept; equals !full.
REQ-010 cmd_write  in  1  1 = write, 0 = read.
REQ-011 cmd_addr  in  ADDR_W  target address.
REQ-012 cmd_wdata  in  DATA_W  write data.
REQ-013 cmd_strb  in  DATA_W/8  write byte strobes.
REQ-014 rsp_valid  out  1  response held.
REQ-015 rsp_ready  in  1  response consumed.
REQ-016 rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
REQ-017 rsp_err  out  2  status: 00 OK, 01 SLVERR, 10 TIMEOUT.
REQ-018 paddr, pwdata, pstrb, pwrite, psel, penable  out  standard APB master signals.
REQ-019 prdata, pready, pslverr  in  standard APB completer returns.

Function
REQ-020 Command FIFO push shall occur on cmd_valid && cmd_ready; it is in-order and holds DEPTH entries.
REQ-021 FSM states shall be IDLE, SETUP and ACCESS.
REQ-022 IDLE->SETUP shall occur when the FIFO is non-empty and rsp_valid==0, popping the head entry into the APB output registers.
REQ-023 SETUP shall last exactly 1 cycle with psel=1 and penable=0, then go to ACCESS.
REQ-024 ACCESS shall hold psel=1 and penable=1 until pready=1 or the timeout fires, then go to IDLE with psel=0 and penable=0.
REQ-025 paddr, pwdata, pstrb and pwrite shall stay stable from SETUP through the final ACCESS cycle.
REQ-026 On pready=1 in ACCESS, rsp_valid shall assert the next cycle with rsp_rdata=prdata (reads only) and rsp_err=01 if pslverr else 00.
REQ-027 The timeout counter shall clear on SETUP and increment each ACCESS cycle with pready=0.
REQ-028 On reaching TIMEOUT, the transfer shall abort, rsp_err=10, rsp_rdata=0, and the FSM shall go to IDLE.
REQ-029 pready=1 in the same cycle the timeout fires shall complete normally; pready wins.
REQ-030 rsp_valid shall hold until rsp_valid && rsp_ready, then clear the next cycle.
REQ-031 No new transfer shall start while rsp_valid=1; minimum spacing is 3 cycles per transfer with rsp_ready tied high.
REQ-032 Push and pop in the same cycle shall leave the FIFO count unchanged.
REQ-033 When the FIFO is full, cmd_ready=0 and cmd_valid shall be ignored.
REQ-034 Pointers shall wrap modulo DEPTH, using an extra MSB for full/empty detection.
REQ-035 pstrb shall be driven 0 for reads; pwdata shall be a don't-care for reads but registered anyway.

Reset
REQ-036 On rst_n=0, asynchronously: FSM to IDLE, FIFO flushed, timeout counter cleared.
REQ-037 On rst_n=0, psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata and rsp_err shall all be 0.
REQ-038 cmd_ready shall be 1 after reset, given an empty FIFO.
REQ-039 Reset during SETUP or ACCESS shall drop psel the same cycle, discard the in-flight transfer and produce no response.

Structure
REQ-040 Package apb_pkg shall hold the state enum (IDLE/SETUP/ACCESS), the rsp_err encodings (RSP_OK, RSP_SLVERR, RSP_TIMEOUT) and a command struct {write, addr, wdata, strb}.
REQ-041 The FIFO shall be a sub-module apb_cmd_fifo, parametrised by DEPTH and the command struct type.

Verification
REQ-042 Write 0x0C <- 0xDEADBEEF, strb 0xF, pready=1 immediately -> psel high 2 cycles, then rsp_valid with rsp_err=00.
REQ-043 Read 0x10 with 3 wait states and prdata=0x12345678 -> penable high 4 cycles, rsp_rdata=0x12345678, rsp_err=00.
REQ-044 Read with pslverr=1 on completion -> rsp_err=01.
REQ-045 TIMEOUT=16 with pready held 0 -> abort after 16 ACCESS cycles, rsp_err=10, then a following queued command still completes.
REQ-046 Push 5 commands with DEPTH=4 and rsp_ready=0 -> cmd_ready drops after 4; release rsp_ready -> all 4 complete in order with no APB overlap.
REQ-047 Assert rst_n=0 mid-ACCESS -> psel and penable 0 immediately, no rsp_valid, cmd_ready=1 after release.
